// File: rtl/uart_cmd_parser.sv
// Framed UART command parser: assembles channel/adder/amplitude into shadow registers and commits atomically.
// Optional checksum byte before EOM is enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_parser #(
    parameter int NUM_CH         = 4,
    parameter int WORD_BYTES     = 4,
    parameter int ADDER_RST      = 1367925,
    parameter int AMPL_RST       = 1000000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           from_uart_ready,
    input  logic [7:0]                     from_uart_data,
    input  logic                           from_uart_error,
    input  logic                           from_uart_valid,
    output logic [NUM_CH*8*WORD_BYTES-1:0] adder,
    output logic [NUM_CH*8*WORD_BYTES-1:0] amplitude,
    output logic [NUM_CH-1:0]              update_strobe,
    output logic                           frame_err,
    output logic [7:0]                     err_count
);
    localparam int W = 8 * WORD_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CH    = 3'd1,
        ST_ADDER = 3'd2,
        ST_AMPL  = 3'd3,
`ifdef UART_CMD_CHECKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_EOM   = 3'd5
    } state_t;

    state_t      state_r, state_n;
    logic [2:0]  cnt_r, cnt_n;
    logic [31:0] tmo_r;
    logic [7:0]  sh_ch_r;
    logic [W-1:0] sh_adder_r, sh_ampl_r;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]  sh_chk_r, rx_chk_r;
`endif
    logic byte_s, last_s, tmo_hit_s, eom_ok_s, commit_s, fault_s;

    // Next-state decode, commit and fault detection
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        commit_s  = 1'b0;
        fault_s   = 1'b0;
        byte_s    = from_uart_valid && from_uart_ready;
        last_s    = (cnt_r == 3'(WORD_BYTES - 1));
        tmo_hit_s = (state_r != ST_IDLE) && (tmo_r == 32'(TIMEOUT_CYCLES - 1));
`ifdef UART_CMD_CHECKSUM_EN
        eom_ok_s  = (from_uart_data == 8'h65) && ({1'b0, sh_ch_r} < 9'(NUM_CH)) && (sh_chk_r == rx_chk_r);
`else
        eom_ok_s  = (from_uart_data == 8'h65) && ({1'b0, sh_ch_r} < 9'(NUM_CH));
`endif
        if (byte_s) begin
            if (state_r != ST_IDLE && from_uart_error) begin
                fault_s = 1'b1;
                state_n = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (from_uart_data == 8'h73) begin
                            state_n = ST_CH;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                    ST_CH: begin
                        state_n = ST_ADDER;
                        cnt_n   = 3'd0;
                    end
                    ST_ADDER: begin
                        if (last_s) begin
                            state_n = ST_AMPL;
                            cnt_n   = 3'd0;
                        end else begin
                            cnt_n = cnt_r + 3'd1;
                        end
                    end
                    ST_AMPL: begin
                        if (last_s) begin
`ifdef UART_CMD_CHECKSUM_EN
                            state_n = ST_CHK;
`else
                            state_n = ST_EOM;
`endif
                            cnt_n = 3'd0;
                        end else begin
                            cnt_n = cnt_r + 3'd1;
                        end
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    ST_CHK: state_n = ST_EOM;
`endif
                    ST_EOM: begin
                        state_n  = ST_IDLE;
                        commit_s = eom_ok_s;
                        fault_s  = !eom_ok_s;
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end else if (tmo_hit_s) begin
            fault_s = 1'b1;
            state_n = ST_IDLE;
        end else begin
            state_n = state_r;
        end
    end

    // Sequencer state, inter-byte timeout and shadow frame assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            tmo_r      <= 32'd0;
            sh_ch_r    <= 8'd0;
            sh_adder_r <= '0;
            sh_ampl_r  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            sh_chk_r   <= 8'd0;
            rx_chk_r   <= 8'd0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (byte_s || state_n == ST_IDLE) begin
                tmo_r <= 32'd0;
            end else begin
                tmo_r <= tmo_r + 32'd1;
            end
            if (byte_s && !from_uart_error) begin
                case (state_r)
                    ST_CH: begin
                        sh_ch_r    <= from_uart_data;
                        sh_adder_r <= '0;
                        sh_ampl_r  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                        sh_chk_r   <= from_uart_data;
`endif
                    end
                    ST_ADDER: begin
                        sh_adder_r <= (sh_adder_r << 8) | W'(from_uart_data);
`ifdef UART_CMD_CHECKSUM_EN
                        sh_chk_r   <= sh_chk_r ^ from_uart_data;
`endif
                    end
                    ST_AMPL: begin
                        sh_ampl_r <= (sh_ampl_r << 8) | W'(from_uart_data);
`ifdef UART_CMD_CHECKSUM_EN
                        sh_chk_r  <= sh_chk_r ^ from_uart_data;
`endif
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    ST_CHK: rx_chk_r <= from_uart_data;
`endif
                    default: sh_ch_r <= sh_ch_r;
                endcase
            end
        end
    end

    // Registered outputs: channel commit, strobes, error pulse and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            from_uart_ready <= 1'b0;
            update_strobe   <= '0;
            frame_err       <= 1'b0;
            err_count       <= 8'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                adder[c*W +: W]     <= W'(ADDER_RST);
                amplitude[c*W +: W] <= W'(AMPL_RST);
            end
        end else begin
            from_uart_ready <= 1'b1;
            frame_err       <= fault_s;
            if (fault_s && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end else begin
                err_count <= err_count;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (commit_s && sh_ch_r == 8'(c)) begin
                    adder[c*W +: W]     <= sh_adder_r;
                    amplitude[c*W +: W] <= sh_ampl_r;
                    update_strobe[c]    <= 1'b1;
                end else begin
                    update_strobe[c]    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected commits/errors are queued at stimulus time and matched on output.
module tb_uart_cmd_parser;
    localparam int NCH = 4;
    localparam int TMO = 40;
    localparam logic [31:0] ARST = 32'd1367925;
    localparam logic [31:0] MRST = 32'd1000000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ready;
    logic [7:0]       data = 8'd0;
    logic             uerr = 1'b0;
    logic             valid = 1'b0;
    logic [NCH*32-1:0] adder, amplitude;
    logic [NCH-1:0]   update_strobe;
    logic             frame_err;
    logic [7:0]       err_count;

    typedef struct {
        logic        is_commit;
        logic [7:0]  ch;
        logic [31:0] add;
        logic [31:0] amp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_add[NCH];
    logic [31:0] m_amp[NCH];
    logic [7:0]  m_err;
    int          n_checks = 0;
    int          n_pass = 0;

    uart_cmd_parser #(.NUM_CH(NCH), .WORD_BYTES(4), .ADDER_RST(1367925),
                      .AMPL_RST(1000000), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .from_uart_ready(ready), .from_uart_data(data),
        .from_uart_error(uerr), .from_uart_valid(valid), .adder(adder),
        .amplitude(amplitude), .update_strobe(update_strobe),
        .frame_err(frame_err), .err_count(err_count));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_add[c] = ARST;
            m_amp[c] = MRST;
        end
        m_err = 8'd0;
    endtask

    task automatic check_channels();
        for (int c = 0; c < NCH; c++) begin
            check_eq($sformatf("adder[%0d]", c), 64'(adder[c*32 +: 32]), 64'(m_add[c]));
            check_eq($sformatf("ampl[%0d]", c), 64'(amplitude[c*32 +: 32]), 64'(m_amp[c]));
        end
    endtask

    task automatic push_commit(input logic [7:0] ch, input logic [31:0] a, input logic [31:0] m);
        exp_t e;
        e.is_commit = 1'b1; e.ch = ch; e.add = a; e.amp = m;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_commit = 1'b0; e.ch = 8'd0; e.add = 32'd0; e.amp = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        @(negedge clk);
        valid = 1'b1; data = b; uerr = e;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid = 1'b0; uerr = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [31:0] a, input logic [31:0] m,
                              input logic [7:0] eom, input logic [7:0] chk_delta);
        logic [7:0] chk;
        chk = ch;
        send_byte(8'h73, 1'b0);
        send_byte(ch, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            send_byte(a[i*8 +: 8], 1'b0);
            chk = chk ^ a[i*8 +: 8];
        end
        for (int i = 3; i >= 0; i--) begin
            send_byte(m[i*8 +: 8], 1'b0);
            chk = chk ^ m[i*8 +: 8];
        end
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(chk ^ chk_delta, 1'b0);
`else
        if (chk_delta != 8'd0) chk = 8'd0;
`endif
        send_byte(eom, 1'b0);
    endtask

    // Scoreboard monitor: every strobe or error pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (update_strobe != '0 || frame_err)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", 64'({update_strobe, frame_err}), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_commit) begin
                    check_eq("strobe", 64'(update_strobe), 64'(4'b0001 << e.ch));
                    check_eq("no_err_on_commit", 64'(frame_err), 64'd0);
                    m_add[e.ch[1:0]] = e.add;
                    m_amp[e.ch[1:0]] = e.amp;
                end else begin
                    check_eq("frame_err", 64'(frame_err), 64'd1);
                    check_eq("no_strobe_on_err", 64'(update_strobe), 64'd0);
                    if (m_err != 8'hFF) m_err = m_err + 8'd1;
                    check_eq("err_count", 64'(err_count), 64'(m_err));
                end
                check_channels();
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_strobe", 64'(update_strobe), 64'd0);
        check_eq("rst_frame_err", 64'(frame_err), 64'd0);
        check_eq("rst_err_count", 64'(err_count), 64'd0);
        check_channels();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_release", 64'(ready), 64'd1);

        // Idle noise including an errored byte is ignored silently
        send_byte(8'h41, 1'b0);
        send_byte(8'h65, 1'b1);
        idle(3);
        check_eq("idle_noise_err_count", 64'(err_count), 64'd0);

        push_commit(8'd2, 32'h0012_3456, 32'd1000);
        send_frame(8'd2, 32'h0012_3456, 32'd1000, 8'h65, 8'd0);
        push_err();
        send_frame(8'd2, 32'hDEAD_BEEF, 32'd77, 8'h58, 8'd0);
        push_commit(8'd1, 32'hCAFE_0001, 32'h0000_FFFF);
        send_frame(8'd1, 32'hCAFE_0001, 32'h0000_FFFF, 8'h65, 8'd0);
        push_err();
        send_frame(8'd7, 32'h1111_2222, 32'h3333_4444, 8'h65, 8'd0);
        idle(2);

        // Receiver error on the 4th byte aborts; the next 's' starts clean
        push_err();
        send_byte(8'h73, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h12, 1'b1);
        push_commit(8'd3, 32'h7300_6573, 32'h0000_0073);
        send_frame(8'd3, 32'h7300_6573, 32'h0000_0073, 8'h65, 8'd0);
        idle(3);

        // Inter-byte timeout after 5 bytes; leftover bytes must not commit
        send_byte(8'h73, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        idle(TMO - 8);
        push_err();
        idle(16);
        check_eq("timeout_seen", 64'(exp_q.size()), 64'd0);
        send_byte(8'h56, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0); send_byte(8'hE8, 1'b0); send_byte(8'h65, 1'b0);
        idle(4);

`ifdef UART_CMD_CHECKSUM_EN
        push_commit(8'd0, 32'h0012_3456, 32'd1000);
        send_frame(8'd0, 32'h0012_3456, 32'd1000, 8'h65, 8'd0);
        push_err();
        send_frame(8'd0, 32'h0000_0001, 32'd5, 8'h65, 8'd1);
        idle(2);
`endif

        // Reset mid-frame returns everything to reset values
        send_byte(8'h73, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h11, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_ready", 64'(ready), 64'd0);
        check_eq("midrst_err_count", 64'(err_count), 64'd0);
        check_channels();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_midrst", 64'(ready), 64'd1);
        push_commit(8'd0, 32'h0102_0304, 32'h0506_0708);
        send_frame(8'd0, 32'h0102_0304, 32'h0506_0708, 8'h65, 8'd0);
        idle(2);

        // Saturate the error counter with back-to-back rejected frames
        for (int i = 0; i < 300; i++) begin
            push_err();
            send_frame(8'(4 + (i % 200)), 32'(i), 32'(i * 3), 8'h65, 8'd0);
        end
        idle(4);
        check_eq("err_count_sat", 64'(err_count), 64'hFF);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Multi-channel UART command parser for the waveform generator. Sits between the UART byte receiver (ready/valid/error byte stream) and the NCO/amplitude stages. It parses framed commands carrying a channel number, a phase-increment (adder) word and an amplitude word. Each frame is assembled into shadow registers and committed to one channel atomically only when the frame is valid, so a corrupted frame never leaves a channel half-updated.

## Interface
Parameters:
- NUM_CH, 4: number of output channels (1..256).
- WORD_BYTES, 4: bytes per adder/amplitude word (1..4); word width W = 8*WORD_BYTES.
- ADDER_RST, 1367925: reset value of every channel's adder (truncated to W).
- AMPL_RST, 1000000: reset value of every channel's amplitude (truncated to W).
- TIMEOUT_CYCLES, 1000000: maximum clk cycles between bytes inside a frame before abort (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- from_uart_ready  out  1  byte-accept flag to the UART receiver.
- from_uart_data  in  8  received byte.
- from_uart_error  in  1  receiver error (framing/parity) for the current byte.
- from_uart_valid  in  1  byte strobe; a byte is consumed when valid && ready.
- adder  out  NUM_CH*W  channel c occupies bits [c*W +: W].
- amplitude  out  NUM_CH*W  same packing as adder.
- update_strobe  out  NUM_CH  one-hot, one-cycle pulse on commit to channel c.
- frame_err  out  1  one-cycle pulse on every frame abort/reject.
- err_count  out  8  saturating count of frame_err pulses.

## Operation
- Frame format: 's' (0x73), CH, adder bytes MSB first, amplitude bytes MSB first, [CHK], 'e' (0x65).
- States: IDLE → CH → ADDER → AMPL → [CHK] → EOM → IDLE. A byte counter (0..WORD_BYTES-1) steps through ADDER and AMPL and clears on each state entry.
- IDLE: 's' → CH. Any other byte, including one with from_uart_error, is discarded silently and is not counted.
- CH: latch CH into shadow. Range is not checked here.
- ADDER/AMPL: shadow word = (shadow << 8) | byte. The shadow clears on entry, so no stale bits survive when WORD_BYTES < 4.
- EOM: commit if byte == 'e', CH < NUM_CH and (when enabled) the checksum matches. On commit, write adder[CH] and amplitude[CH] from shadow and pulse update_strobe[CH]. Otherwise pulse frame_err and leave all channels unchanged. Either way → IDLE.
- Abort (frame_err pulse, → IDLE, shadow discarded) occurs on from_uart_error on any byte outside IDLE, or when the inter-byte timeout expires outside IDLE.
- Timeout counter: resets on every consumed byte and in IDLE. Abort fires on the cycle the count reaches TIMEOUT_CYCLES.
- An 's' arriving mid-frame is treated as data, not as resync.
- err_count increments on each frame_err pulse and holds at 255.

## Timing
- Reset values: from_uart_ready=0, update_strobe=0, frame_err=0, err_count=0, every channel adder=ADDER_RST and amplitude=AMPL_RST, state=IDLE.
- from_uart_ready is 1 from the first clk edge after rst_n deasserts. It stays 1 permanently, and the block consumes one byte per cycle.
- Commit latency: adder/amplitude/update_strobe update on the same clk edge that samples the valid EOM byte. The strobe is high for exactly that one cycle.
- frame_err is high for the one cycle after the edge that detects the fault.
- Timeout and a simultaneous valid byte: the byte wins, and the counter resets.
- rst_n asserted mid-frame: immediate return to reset values, and the partial frame is lost.
- Back-to-back frames with zero idle cycles are fully supported.

## Configuration
- UART_CMD_CHECKSUM_EN defined: the CHK state is present. CHK is the XOR of CH and all adder and amplitude bytes. A mismatch rejects the frame at EOM with frame_err.
- Not defined: no CHK byte. The frame is 2+2*WORD_BYTES+1 bytes, and the byte after the last amplitude byte is EOM.

## Test plan
(NUM_CH=4, WORD_BYTES=4, checksum off unless stated.)
- Reset release: idle bus → ready=1 after one edge; all four adders=1367925 and amplitudes=1000000; err_count=0.
- Valid frame 's',0x02,0x00,0x12,0x34,0x56,0x00,0x00,0x03,0xE8,'e' → adder[2]=0x00123456, amplitude[2]=1000, update_strobe=0b0100 for one cycle, other channels unchanged.
- Bad EOM: same frame ending 0x58 → frame_err pulse, err_count=1, channel 2 unchanged. The next valid frame to channel 1 commits normally.
- CH=0x07 with a valid body and 'e' → frame_err, no strobe. from_uart_error on the 4th byte → abort; the following 's' starts a clean frame.
- Timeout: stop after 5 bytes for TIMEOUT_CYCLES cycles → frame_err, state IDLE. Resuming with the remaining bytes produces no commit.
- UART_CMD_CHECKSUM_EN: frame with CHK=0x02^0x12^0x34^0x56^0x03^0xE8 → commit. CHK off by one → frame_err. Also drive 300 bad frames → err_count=255 (saturated).
